// File: rtl/htif_bus_target.sv
// htif bus responder: services htif bus_req_*/bus_res_* traffic against a word RAM and a small
// MMIO window (TOHOST mailbox, free-running CYCLE counter, SCRATCH register).
// Writes are posted. Reads answer a fixed READ_LATENCY cycles after accept.
module htif_bus_target #(
  parameter int unsigned ADDR_W       = 10,
  parameter int unsigned READ_LATENCY = 2
) (
  input  logic        clock,
  input  logic        reset_n,
  output logic        bus_req_ready,
  input  logic        bus_req_read,
  input  logic        bus_req_write,
  input  logic [31:0] bus_req_address,
  input  logic [31:0] bus_req_data,
  output logic        bus_res_valid,
  output logic [31:0] bus_res_data,
  output logic        tohost_valid,
  output logic [31:0] tohost_data,
  input  logic        tohost_ack,
  output logic        err
);

  localparam int unsigned RamWords = 1 << ADDR_W;
  localparam logic [2:0]  LatM1    = 3'(READ_LATENCY - 1);

  // MMIO word addresses (byte address >> 2)
  localparam logic [29:0] WordTohost  = 30'h2000_0000;
  localparam logic [29:0] WordCycle   = 30'h2000_0001;
  localparam logic [29:0] WordScratch = 30'h2000_0002;

  typedef enum logic [0:0] {StIdle, StRdWait} state_e;

  state_e      r_state, w_state_d;
  logic [2:0]  r_cnt, w_cnt_d;
  logic        r_ready, w_ready_d;
  logic [31:0] r_rdata;
  logic [31:0] r_cycle;
  logic [31:0] r_scratch;
  logic        r_tohost_valid, w_tohost_valid_d;
  logic [31:0] r_tohost_data, w_tohost_data_d;
  logic        r_err;
  logic [31:0] r_mem [RamWords];

  logic              w_acc, w_acc_rd, w_acc_wr;
  logic              w_is_ram, w_is_tohost, w_is_cycle, w_is_scratch, w_is_unmapped;
  logic [29:0]       w_word;
  logic [ADDR_W-1:0] w_ram_idx;
  logic [31:0]       w_rd_data;
  logic              w_err_set;
  logic              w_res_fire;
  logic              w_unused_addr;

  // Byte lane bits carry no information for word-only access
  assign w_unused_addr = ^bus_req_address[1:0];

  assign w_acc    = r_ready & (bus_req_read | bus_req_write);
  assign w_acc_rd = r_ready & bus_req_read;
  assign w_acc_wr = r_ready & bus_req_write;

  assign w_word        = bus_req_address[31:2];
  assign w_ram_idx     = bus_req_address[ADDR_W+1:2];
  assign w_is_ram      = (bus_req_address[31:28] == 4'h0);
  assign w_is_tohost   = (w_word == WordTohost);
  assign w_is_cycle    = (w_word == WordCycle);
  assign w_is_scratch  = (w_word == WordScratch);
  assign w_is_unmapped = !(w_is_ram | w_is_tohost | w_is_cycle | w_is_scratch);

  assign w_err_set = w_acc & ((bus_req_read & bus_req_write) | w_is_unmapped |
                              (bus_req_write & w_is_cycle));

  // Read data as seen in the accept cycle; a same-cycle write wins (write-first)
  always_comb begin
    w_rd_data = 32'h0;
    if (w_is_ram) begin
      w_rd_data = w_acc_wr ? bus_req_data : r_mem[w_ram_idx];
    end else if (w_is_tohost) begin
      w_rd_data = w_acc_wr ? bus_req_data : r_tohost_data;
    end else if (w_is_cycle) begin
      w_rd_data = r_cycle;
    end else if (w_is_scratch) begin
      w_rd_data = w_acc_wr ? bus_req_data : r_scratch;
    end else begin
      w_rd_data = 32'hDEAD_BEEF;
    end
  end

  // Read sequencer next-state: park in RdWait until the countdown expires
  always_comb begin
    w_state_d  = r_state;
    w_cnt_d    = r_cnt;
    w_res_fire = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (w_acc_rd) begin
          w_state_d = StRdWait;
          w_cnt_d   = LatM1;
        end
      end
      StRdWait: begin
        if (r_cnt == 3'd0) begin
          w_res_fire = 1'b1;
          w_state_d  = StIdle;
        end else begin
          w_cnt_d = r_cnt - 3'd1;
        end
      end
      default: w_state_d = StIdle;
    endcase
  end

  // Mailbox next-state: a TOHOST write loads it, an ack while full drains it
  always_comb begin
    w_tohost_valid_d = r_tohost_valid;
    w_tohost_data_d  = r_tohost_data;
    if (w_acc_wr && w_is_tohost) begin
      w_tohost_valid_d = 1'b1;
      w_tohost_data_d  = bus_req_data;
    end else if (r_tohost_valid && tohost_ack) begin
      w_tohost_valid_d = 1'b0;
    end
  end

  // Ready is registered; a full mailbox stalls every request
  assign w_ready_d = (w_state_d == StIdle) & !w_tohost_valid_d;

  // Control and MMIO state
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state        <= StIdle;
      r_cnt          <= 3'd0;
      r_ready        <= 1'b1;
      r_rdata        <= 32'h0;
      r_cycle        <= 32'h0;
      r_scratch      <= 32'h0;
      r_tohost_valid <= 1'b0;
      r_tohost_data  <= 32'h0;
      r_err          <= 1'b0;
    end else begin
      r_state        <= w_state_d;
      r_cnt          <= w_cnt_d;
      r_ready        <= w_ready_d;
      r_cycle        <= r_cycle + 32'd1;
      r_tohost_valid <= w_tohost_valid_d;
      r_tohost_data  <= w_tohost_data_d;
      if (w_acc_rd) begin
        r_rdata <= w_rd_data;
      end
      if (w_acc_wr && w_is_scratch) begin
        r_scratch <= bus_req_data;
      end
      if (w_err_set) begin
        r_err <= 1'b1;
      end
    end
  end

  // Word RAM; contents deliberately not reset
  always_ff @(posedge clock) begin
    if (w_acc_wr && w_is_ram) begin
      r_mem[w_ram_idx] <= bus_req_data;
    end
  end

  assign bus_req_ready = r_ready;
  assign bus_res_valid = w_res_fire;
  assign bus_res_data  = w_res_fire ? r_rdata : 32'h0;
  assign tohost_valid  = r_tohost_valid;
  assign tohost_data   = r_tohost_data;
  assign err           = r_err;

endmodule
